alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 6, which sets the datapath width of the 6-bit ripple ALU it drives.
REQ-002 SHALL have `clk`, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have `reset`, input, 1, asynchronous, active-high.
REQ-004 SHALL have `instr_valid` in 1 and `instr_ready` out 1 for the instruction handshake.
REQ-005 SHALL have `instr_op` in 4, the ALUOp code, passed through to the ALU unchanged.
REQ-006 SHALL have `instr_rs` in 3, `instr_rt` in 3, `instr_rd` in 3: source A, source B and destination register indices.
REQ-007 SHALL have `instr_cin` in 1, the requested CarryIn.
REQ-008 SHALL have ALU-side outputs `alu_a` WIDTH, `alu_b` WIDTH, `alu_cin` 1 and `alu_op` 4.
REQ-009 SHALL have ALU-side inputs `alu_result` WIDTH and `alu_cout` 1.
REQ-010 SHALL have `done` out 1, a one-cycle writeback pulse.
REQ-011 SHALL have `last_cout` out 1, the CarryOut of the last completed instruction.
REQ-012 SHALL have `dbg_we` in 1, `dbg_addr` in 3, `dbg_wdata` in WIDTH and `dbg_rdata` out WIDTH, a register-file preload and inspect port.

Function
REQ-013 SHALL contain a register file of 8 x WIDTH; r0 reads 0 and writes to it are discarded.
REQ-014 SHALL implement FSM states IDLE, READ, EXEC and WRITE:
- IDLE -> READ on `instr_valid && instr_ready`, latching op, rs, rt, rd and cin.
- READ -> EXEC, EXEC -> WRITE and WRITE -> IDLE, each unconditionally.
REQ-015 SHALL assert `instr_ready` only in IDLE.
REQ-016 SHALL ignore `instr_valid` outside IDLE.
REQ-017 SHALL register `alu_a = rf[rs]`, `alu_b = rf[rt]`, `alu_op` and `alu_cin` at the READ->EXEC edge.
REQ-018 SHALL hold `alu_a`, `alu_b`, `alu_op` and `alu_cin` stable until the next READ->EXEC edge.
REQ-019 SHALL capture `alu_result` and `alu_cout` at the EXEC->WRITE edge; EXEC is the one-cycle ripple settle time.
REQ-020 SHALL write the captured result to rf[rd] and update `last_cout` at the WRITE->IDLE edge.
REQ-021 SHALL assert `done` combinationally while in WRITE (Moore output).
REQ-022 SHALL meet this latency: accepted at edge N, rf[rd] visible at edge N+3, next accept no earlier than edge N+4 (4 cycles per instruction).
REQ-023 SHALL honour `dbg_we` only in IDLE and ignore it otherwise; an IDLE write in the same cycle as an accept lands first, so READ sees the new value.
REQ-024 SHALL drive `dbg_rdata = rf[dbg_addr]` combinationally.
REQ-025 SHALL allow rd to equal rs or rt; operands are the pre-write values.
REQ-026 SHALL treat rs = rt as legal; the same value drives both operands.

Reset
REQ-027 SHALL on `reset` asynchronously enter IDLE and clear every rf entry.
REQ-028 SHALL on `reset` clear `alu_a`, `alu_b`, `alu_op`, `alu_cin`, `last_cout` and `done`; `instr_ready` becomes 1 on the first clock after release.
REQ-029 SHALL on reset mid-instruction discard the in-flight instruction: no rf write and no `done`.

Configuration
REQ-030 SHALL provide macro `ALU_CARRY_FLAG_EN` controlling a carry flag:
- Defined: add output `carry_flag` 1 (reset 0), updated with the captured `alu_cout` in WRITE; `alu_cin` is loaded from `carry_flag` and `instr_cin` is ignored (multi-word chaining).
- Undefined: `alu_cin` is loaded from the latched `instr_cin` and there is no `carry_flag` port.

Verification
Bench ALU model: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a + ~b + cin).
REQ-031 SHALL verify preload r1 = 6'd20 and r2 = 6'd15, then op 0010 with rs1, rt2, rd3, cin0 -> r3 = 35, `last_cout` 0, `done` exactly once, 3 cycles after accept.
REQ-032 SHALL verify r1 = 63, r2 = 1, ADD into r4 -> r4 = 0 and `last_cout` 1.
REQ-033 SHALL verify SUB r1 = 10, r2 = 3 with cin1 into r0 -> r0 still reads 0 and `done` pulses.
REQ-034 SHALL verify back-to-back `instr_valid` held high -> accepts exactly 4 cycles apart and `instr_ready` low in READ, EXEC and WRITE.
REQ-035 SHALL verify `reset` asserted during EXEC of ADD into r5 -> r5 = 0, no `done`, FSM IDLE.
REQ-036 SHALL verify, with `ALU_CARRY_FLAG_EN` defined, ADD 63 + 1 then ADD 0 + 0 with cin0 -> second result = 1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Four-state issue/writeback sequencer driving an external ripple ALU from an 8-entry register file.
// Optional carry flag chaining is enabled with `define ALU_CARRY_FLAG_EN.
module alu_issue_stage #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_op,
   input  logic [2:0]       instr_rs,
   input  logic [2:0]       instr_rt,
   input  logic [2:0]       instr_rd,
   input  logic             instr_cin,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   output logic             done,
   output logic             last_cout,
   input  logic             dbg_we,
   input  logic [2:0]       dbg_addr,
   input  logic [WIDTH-1:0] dbg_wdata,
   output logic [WIDTH-1:0] dbg_rdata
`ifdef ALU_CARRY_FLAG_EN
   ,
   output logic             carry_flag
`endif
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   state_t           state_q, state_d;
   logic             ready_en_q, ready_en_d;
   logic [3:0]       op_q, op_d;
   logic [2:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic             cin_q, cin_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic             alu_cin_q, alu_cin_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;
   logic             last_cout_q, last_cout_d;
   logic             flag_q, flag_d;
   logic [WIDTH-1:0] rf_q [8];
   logic [WIDTH-1:0] rf_d [8];

   always_comb begin
      state_d     = state_q;
      ready_en_d  = 1'b1;
      op_d        = op_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      cin_d       = cin_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_cin_d   = alu_cin_q;
      alu_op_d    = alu_op_q;
      res_d       = res_q;
      cout_d      = cout_q;
      last_cout_d = last_cout_q;
      flag_d      = flag_q;
      rf_d        = rf_q;
      case (state_q)
         IDLE: begin
            // Debug write lands in the same edge as an accept, so READ sees it.
            if (dbg_we && dbg_addr != 3'd0) rf_d[dbg_addr] = dbg_wdata;
            if (instr_valid && instr_ready) begin
               op_d    = instr_op;
               rs_d    = instr_rs;
               rt_d    = instr_rt;
               rd_d    = instr_rd;
               cin_d   = instr_cin;
               state_d = READ;
            end
         end
         READ: begin
            alu_a_d  = rf_q[rs_q];
            alu_b_d  = rf_q[rt_q];
            alu_op_d = op_q;
`ifdef ALU_CARRY_FLAG_EN
            alu_cin_d = flag_q;
`else
            alu_cin_d = cin_q;
`endif
            state_d  = EXEC;
         end
         EXEC: begin
            res_d   = alu_result;
            cout_d  = alu_cout;
            state_d = WRITE;
         end
         WRITE: begin
            if (rd_q != 3'd0) rf_d[rd_q] = res_q;
            last_cout_d = cout_q;
            flag_d      = cout_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_en_q  <= 1'b0;
         op_q        <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         cin_q       <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_cin_q   <= 1'b0;
         alu_op_q    <= '0;
         res_q       <= '0;
         cout_q      <= 1'b0;
         last_cout_q <= 1'b0;
         flag_q      <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         ready_en_q  <= ready_en_d;
         op_q        <= op_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         cin_q       <= cin_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_cin_q   <= alu_cin_d;
         alu_op_q    <= alu_op_d;
         res_q       <= res_d;
         cout_q      <= cout_d;
         last_cout_q <= last_cout_d;
         flag_q      <= flag_d;
         rf_q        <= rf_d;
      end
   end

   // Ready is held off until the first clock after reset release.
   assign instr_ready = (state_q == IDLE) && ready_en_q;
   assign done        = (state_q == WRITE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_cin     = alu_cin_q;
   assign alu_op      = alu_op_q;
   assign last_cout   = last_cout_q;
   assign dbg_rdata   = rf_q[dbg_addr];
`ifdef ALU_CARRY_FLAG_EN
   assign carry_flag  = flag_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage with a behavioural register-file/ALU model.
module tb_alu_issue_stage;
   localparam int W = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         instr_valid, instr_ready;
   logic [3:0]   instr_op;
   logic [2:0]   instr_rs, instr_rt, instr_rd;
   logic         instr_cin;
   logic [W-1:0] alu_a, alu_b;
   logic         alu_cin;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_result;
   logic         alu_cout;
   logic         done, last_cout;
   logic         dbg_we;
   logic [2:0]   dbg_addr;
   logic [W-1:0] dbg_wdata, dbg_rdata;
`ifdef ALU_CARRY_FLAG_EN
   logic         carry_flag;
   localparam bit FLAG_EN = 1'b1;
`else
   localparam bit FLAG_EN = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] m_rf [8];
   logic         m_last;
   logic         m_flag;

   alu_issue_stage #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
      .instr_cin(instr_cin),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .done(done), .last_cout(last_cout),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
`ifdef ALU_CARRY_FLAG_EN
      , .carry_flag(carry_flag)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, b, input logic ci);
      case (op)
         4'b0000: return {1'b0, a & b};
         4'b0001: return {1'b0, a | b};
         4'b0010: return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
         4'b0110: return {1'b0, a} + {1'b0, ~b} + (W+1)'(ci);
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   // External ripple ALU seen by the DUT
   always_comb {alu_cout, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_cin);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_last = 1'b0;
      m_flag = 1'b0;
   endtask

   task automatic model_exec(input logic [3:0] op, input logic [2:0] rs, rt, rd, input logic cin,
                             output logic [W-1:0] ea, eb, output logic eci);
      logic [W:0] r;
      ea  = m_rf[rs];
      eb  = m_rf[rt];
      eci = FLAG_EN ? m_flag : cin;
      r   = alu_fn(op, ea, eb, eci);
      if (rd != 3'd0) m_rf[rd] = r[W-1:0];
      m_last = r[W];
      m_flag = r[W];
   endtask

   task automatic read_rf(input string tag, input logic [2:0] a);
      dbg_addr = a;
      #1;
      check(tag, 32'(dbg_rdata), 32'(m_rf[a]));
   endtask

   // Enter and leave on a falling edge while the DUT is idle.
   task automatic preload(input logic [2:0] a, input logic [W-1:0] d);
      dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      if (a != 3'd0) m_rf[a] = d;
      @(posedge clk); #1;
      dbg_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic issue(input logic [3:0] op, input logic [2:0] rs, rt, rd, input logic cin,
                        input bit dbg_same, input logic [2:0] da, input logic [W-1:0] dd,
                        input bit dbg_late, input logic [2:0] ja, input logic [W-1:0] jd);
      logic [W-1:0] ea, eb;
      logic         eci;
      int           k;
      k = 0;
      while (!instr_ready && k < 8) begin @(negedge clk); k++; end
      if (!instr_ready) begin
         check("issue_ready_timeout", 32'(instr_ready), 32'd1);
         return;
      end
      instr_valid = 1'b1; instr_op = op; instr_rs = rs; instr_rt = rt; instr_rd = rd; instr_cin = cin;
      if (dbg_same) begin
         dbg_we = 1'b1; dbg_addr = da; dbg_wdata = dd;
         if (da != 3'd0) m_rf[da] = dd;
      end
      model_exec(op, rs, rt, rd, cin, ea, eb, eci);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      dbg_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("busy_ready", 32'(instr_ready), 32'd0);
         check("done_pulse", 32'(done), (i == 2) ? 32'd1 : 32'd0);
         if (i == 0 && dbg_late) begin
            dbg_we = 1'b1; dbg_addr = ja; dbg_wdata = jd;
         end
         if (i == 1) begin
            dbg_we = 1'b0;
            check("alu_a", 32'(alu_a), 32'(ea));
            check("alu_b", 32'(alu_b), 32'(eb));
            check("alu_op", 32'(alu_op), 32'(op));
            check("alu_cin", 32'(alu_cin), 32'(eci));
         end
      end
      @(negedge clk);
      check("done_after", 32'(done), 32'd0);
      check("ready_after", 32'(instr_ready), 32'd1);
      check("last_cout", 32'(last_cout), 32'(m_last));
`ifdef ALU_CARRY_FLAG_EN
      check("carry_flag", 32'(carry_flag), 32'(m_flag));
`endif
      read_rf("rf_rd", rd);
      if (dbg_late) read_rf("rf_dbg_busy_ignored", ja);
   endtask

   initial begin
      logic [3:0] ops [4];
      int         c;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};
      reset = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rs = '0; instr_rt = '0; instr_rd = '0;
      instr_cin = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_ready_held", 32'(instr_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(instr_ready), 32'd1);
      check("rst_last_cout", 32'(last_cout), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_alu_cin", 32'(alu_cin), 32'd0);
      read_rf("rst_rf7", 3'd7);

      // 20 + 15 into r3
      preload(3'd1, 6'd20);
      preload(3'd2, 6'd15);
      issue(4'b0010, 3'd1, 3'd2, 3'd3, 1'b0, 0, 3'd0, '0, 0, 3'd0, '0);
      dbg_addr = 3'd3; #1;
      check("add_20_15", 32'(dbg_rdata), 32'd35);
      check("add_20_15_cout", 32'(last_cout), 32'd0);

      // 63 + 1 wraps with carry
      preload(3'd1, 6'd63);
      preload(3'd2, 6'd1);
      issue(4'b0010, 3'd1, 3'd2, 3'd4, 1'b0, 0, 3'd0, '0, 0, 3'd0, '0);
      dbg_addr = 3'd4; #1;
      check("add_wrap", 32'(dbg_rdata), 32'd0);
      check("add_wrap_cout", 32'(last_cout), 32'd1);

`ifdef ALU_CARRY_FLAG_EN
      preload(3'd1, 6'd0);
      preload(3'd2, 6'd0);
      issue(4'b0010, 3'd1, 3'd2, 3'd5, 1'b0, 0, 3'd0, '0, 0, 3'd0, '0);
      dbg_addr = 3'd5; #1;
      check("carry_chain", 32'(dbg_rdata), 32'd1);
`endif

      // SUB into r0 is discarded
      preload(3'd1, 6'd10);
      preload(3'd2, 6'd3);
      issue(4'b0110, 3'd1, 3'd2, 3'd0, 1'b1, 0, 3'd0, '0, 0, 3'd0, '0);
      dbg_addr = 3'd0; #1;
      check("r0_zero", 32'(dbg_rdata), 32'd0);

      // Back-to-back with valid held high
      instr_valid = 1'b1; instr_op = 4'b0010; instr_rs = 3'd1; instr_rt = 3'd2; instr_rd = 3'd3; instr_cin = 1'b0;
      for (c = 0; c < 12; c++) begin
         check("b2b_ready", 32'(instr_ready), (c % 4 == 0) ? 32'd1 : 32'd0);
         if (instr_ready) begin
            logic [W-1:0] ea, eb;
            logic         eci;
            model_exec(4'b0010, 3'd1, 3'd2, 3'd3, 1'b0, ea, eb, eci);
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      check("b2b_ready_end", 32'(instr_ready), 32'd1);
      read_rf("b2b_r3", 3'd3);

      // Randomized instructions
      for (int t = 0; t < 24; t++) begin
         preload(3'($urandom_range(1, 7)), W'($urandom));
         issue(ops[$urandom_range(0, 3)], 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
               bit'($urandom_range(0, 1)), 3'($urandom), W'($urandom),
               bit'($urandom_range(0, 1)), 3'($urandom), W'($urandom));
      end

      // Reset during EXEC discards the instruction
      preload(3'd1, 6'd7);
      preload(3'd2, 6'd9);
      instr_valid = 1'b1; instr_op = 4'b0010; instr_rs = 3'd1; instr_rt = 3'd2; instr_rd = 3'd5; instr_cin = 1'b0;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_alu_a", 32'(alu_a), 32'd0);
      model_reset();
      @(negedge clk);
      check("midrst_done_hold", 32'(done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_done", 32'(done), 32'd0);
         check("midrst_idle", 32'(instr_ready), 32'd1);
      end
      read_rf("midrst_r5", 3'd5);
      read_rf("midrst_r1", 3'd1);
      check("midrst_last_cout", 32'(last_cout), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
